// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator: signed fixed-point gain in [0, ONE], one step per sample_en tick.
// Latency: env_out/state_out/env_valid register on the clk edge where sample_en=1.
// Backpressure: none; outputs hold between ticks. Optional macro ADSR_HARD_RESTART_EN selects hard retrigger.
module adsr_envelope #(
    parameter int WI = 2,
    parameter int WF = 14,
    localparam int W = WI + WF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sample_en,
    input  logic         gate,
    input  logic [W-1:0] attack_step,
    input  logic [W-1:0] decay_step,
    input  logic [W-1:0] sustain_lvl,
    input  logic [W-1:0] release_step,
    output logic [W-1:0] env_out,
    output logic         env_valid,
    output logic [2:0]   state_out,
    output logic         busy
);

    localparam logic signed [W:0] ONE_X = (W+1)'(1 << WF);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t            state_q, state_n;
    logic [W-1:0]      env_q;
    logic signed [W:0] env_n;

    // Working values are one bit wider than the output so sums/differences never wrap.
    logic signed [W:0] env_x, att_x, dec_x, rel_x, sus_x;
    logic signed [W:0] att_sum, att_sat, dec_dif, rel_dif, retrig_lvl;
    logic              att_zero, dec_zero, rel_zero;
    logic              unused_step_msbs;

    // Step inputs are magnitudes; their sign bit carries no meaning.
    assign env_x    = $signed({1'b0, env_q});
    assign att_x    = $signed({2'b00, attack_step[W-2:0]});
    assign dec_x    = $signed({2'b00, decay_step[W-2:0]});
    assign rel_x    = $signed({2'b00, release_step[W-2:0]});
    assign att_zero = (attack_step[W-2:0] == '0);
    assign dec_zero = (decay_step[W-2:0] == '0);
    assign rel_zero = (release_step[W-2:0] == '0);
    assign unused_step_msbs = ^{attack_step[W-1], decay_step[W-1], release_step[W-1]};

    assign att_sum = env_x + att_x;
    assign att_sat = (att_sum >= ONE_X) ? ONE_X : att_sum;
    assign dec_dif = env_x - dec_x;
    assign rel_dif = env_x - rel_x;

`ifdef ADSR_HARD_RESTART_EN
    // Hard retrigger: attack restarts from zero.
    assign retrig_lvl = (att_x >= ONE_X) ? ONE_X : att_x;
`else
    // Legato retrigger: attack continues from the current level.
    assign retrig_lvl = att_sat;
`endif

    // Clamp the sustain target into [0, ONE].
    always_comb begin
        sus_x = $signed({1'b0, sustain_lvl});
        if (sustain_lvl[W-1]) begin
            sus_x = '0;
        end else if ($signed({1'b0, sustain_lvl}) > ONE_X) begin
            sus_x = ONE_X;
        end
    end

    // Next state and next level; gate checks win over level checks.
    always_comb begin
        state_n = state_q;
        env_n   = env_x;
        case (state_q)
            S_IDLE: begin
                if (gate) begin
                    state_n = S_ATTACK;
                    env_n   = att_sat;
                end
            end
            S_ATTACK: begin
                if (!gate) begin
                    state_n = S_RELEASE;
                end else if (att_sum >= ONE_X || att_zero) begin
                    state_n = S_DECAY;
                    env_n   = ONE_X;
                end else begin
                    env_n   = att_sum;
                end
            end
            S_DECAY: begin
                if (!gate) begin
                    state_n = S_RELEASE;
                end else if (dec_dif <= sus_x || dec_zero) begin
                    state_n = S_SUSTAIN;
                    env_n   = sus_x;
                end else begin
                    env_n   = dec_dif;
                end
            end
            S_SUSTAIN: begin
                if (!gate) begin
                    state_n = S_RELEASE;
                end else begin
                    env_n   = sus_x;
                end
            end
            S_RELEASE: begin
                if (gate) begin
                    state_n = S_ATTACK;
                    env_n   = retrig_lvl;
                end else if (env_x <= rel_x || rel_zero) begin
                    state_n = S_IDLE;
                    env_n   = '0;
                end else begin
                    env_n   = rel_dif;
                end
            end
            default: begin
                state_n = S_IDLE;
                env_n   = '0;
            end
        endcase
    end

    // State, level and valid pulse advance only on the sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            env_q     <= '0;
            env_valid <= 1'b0;
        end else if (sample_en) begin
            state_q   <= state_n;
            env_q     <= env_n[W-1:0];
            env_valid <= 1'b1;
        end else begin
            env_valid <= 1'b0;
        end
    end

    assign env_out   = env_q;
    assign state_out = state_q;
    assign busy      = (state_q != S_IDLE);

endmodule
